// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg -- shared definitions for the PS/2 keyboard key source.
//   * set-2 prefix bytes (extended, break, pause)
//   * UKNC keycodes produced for the OSD menu
//   * frame receiver and key presentation FSM state types
package ps2_kbd_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;   // extended key prefix
    localparam logic [7:0] SC_F0 = 8'hF0;   // break (key release) prefix
    localparam logic [7:0] SC_E1 = 8'hE1;   // Pause key sequence start

    // Pause sends E1 followed by 7 more bytes that carry no useful key
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // UKNC keycodes (octal, as documented for the UKNC keyboard)
    localparam logic [7:0] KC_UP    = 8'o154;
    localparam logic [7:0] KC_DOWN  = 8'o134;
    localparam logic [7:0] KC_LEFT  = 8'o116;
    localparam logic [7:0] KC_RIGHT = 8'o133;
    localparam logic [7:0] KC_ENTER = 8'o153;
    localparam logic [7:0] KC_ESC   = 8'o006;
    localparam logic [7:0] KC_TAB   = 8'o026;
    localparam logic [7:0] KC_RESET = 8'o004;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PAR,
        FR_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        PR_EMPTY,
        PR_SHOW,
        PR_GAP
    } pres_state_t;

endpackage

// File: rtl/ps2_kbd_src_if.sv
// ps2_kbd_src_if -- OSD key handshake.
//   press_btn : high while a key is presented (source -> OSD)
//   keycode   : UKNC keycode of the presented key, bit 7 always 0 (source -> OSD)
//   read_kbd  : acknowledge, rising edge pops the key (OSD -> source)
// master = keyboard source side, slave = OSD side.
interface ps2_kbd_src_if;
    logic       press_btn;
    logic [7:0] keycode;
    logic       read_kbd;

    modport master (
        output press_btn,
        output keycode,
        input  read_kbd
    );

    modport slave (
        input  press_btn,
        input  keycode,
        output read_kbd
    );
endinterface

// File: rtl/ps2_uknc_map.sv
// ps2_uknc_map -- combinational set-2 make code to UKNC keycode lookup.
//   ext      in  1  byte was preceded by E0
//   scancode in  8  make code byte
//   hit      out 1  code is mapped; when 0 the key is dropped
//   keycode  out 8  UKNC keycode (0 when hit=0)
module ps2_uknc_map
    import ps2_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] scancode,
    output logic       hit,
    output logic [7:0] keycode
);

    always_comb begin
        hit     = 1'b1;
        keycode = 8'h00;
        case ({ext, scancode})
            9'h175:  keycode = KC_UP;
            9'h172:  keycode = KC_DOWN;
            9'h16B:  keycode = KC_LEFT;
            9'h174:  keycode = KC_RIGHT;
            9'h05A:  keycode = KC_ENTER;
            9'h076:  keycode = KC_ESC;
            9'h00D:  keycode = KC_TAB;
            9'h007:  keycode = KC_RESET;
            default: hit     = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_src.sv
// ps2_kbd_src -- PS/2 keyboard to OSD key source.
// Receives PS/2 frames, decodes set-2 make codes (E0/F0/E1 prefixes),
// maps them to UKNC keycodes, queues them and presents one key at a time.
//   clk       in   system clock
//   nrst      in   synchronous reset, active high
//   ps2_clk   in   PS/2 clock line (asynchronous)
//   ps2_data  in   PS/2 data line (asynchronous)
//   kbd       if   master side of the press_btn/keycode/read_kbd handshake
//   frame_err out  one-cycle pulse on parity/start/stop error or timeout
//   overflow  out  sticky, a key was dropped because the queue was full
module ps2_kbd_src
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    ps2_kbd_src_if.master       kbd,
    output logic                frame_err,
    output logic                overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 = ps2_clk, bit 1 = ps2_data
    // ------------------------------------------------------------------
    logic [1:0] line_raw;
    logic [1:0] line_sync;

    assign line_raw = {ps2_data, ps2_clk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic s1_reg;
        logic s2_reg;
        // Lines idle high, so reset to the idle level
        always_ff @(posedge clk) begin
            if (nrst) begin
                s1_reg <= 1'b1;
                s2_reg <= 1'b1;
            end else begin
                s1_reg <= line_raw[gi];
                s2_reg <= s1_reg;
            end
        end
        assign line_sync[gi] = s2_reg;
    end

    logic clk_s;
    logic data_s;
    assign clk_s  = line_sync[0];
    assign data_s = line_sync[1];

    // ------------------------------------------------------------------
    // ps2_clk glitch filter and fall strobe
    // ------------------------------------------------------------------
    logic          filt_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          fall_reg;

    // Counts consecutive samples disagreeing with the filtered level; the
    // level flips on the FILTER_LEN-th one. The fall strobe is produced in
    // the same edge so it lines up with the new filtered level.
    always_ff @(posedge clk) begin
        if (nrst) begin
            filt_reg     <= 1'b1;
            filt_cnt_reg <= '0;
            fall_reg     <= 1'b0;
        end else begin
            fall_reg <= 1'b0;
            if (clk_s == filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                filt_reg     <= clk_s;
                filt_cnt_reg <= '0;
                fall_reg     <= ~clk_s;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frame_state_t fr_state_reg, fr_state_next;
    logic [7:0]   shift_reg, shift_next;
    logic [2:0]   bit_cnt_reg, bit_cnt_next;
    logic         par_reg, par_next;
    logic [15:0]  to_cnt_reg;
    logic         timeout;
    logic         byte_ok;
    logic         frame_bad;
    logic         byte_valid_reg;
    logic         frame_err_reg;

    assign timeout = (fr_state_reg != FR_IDLE) && !fall_reg &&
                     (to_cnt_reg == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        fr_state_next = fr_state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        par_next      = par_reg;
        byte_ok       = 1'b0;
        frame_bad     = 1'b0;
        case (fr_state_reg)
            FR_IDLE: begin
                if (fall_reg) begin
                    if (!data_s) begin
                        fr_state_next = FR_DATA;
                        bit_cnt_next  = 3'd0;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            FR_DATA: begin
                if (fall_reg) begin
                    shift_next   = {data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        fr_state_next = FR_PAR;
                    end
                end
            end
            FR_PAR: begin
                if (fall_reg) begin
                    par_next      = data_s;
                    fr_state_next = FR_STOP;
                end
            end
            FR_STOP: begin
                if (fall_reg) begin
                    // Odd parity: XOR over data and parity bit must be 1
                    if (data_s && (^{shift_reg, par_reg})) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    fr_state_next = FR_IDLE;
                end
            end
            default: fr_state_next = FR_IDLE;
        endcase
        if (timeout) begin
            fr_state_next = FR_IDLE;
            frame_bad     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            fr_state_reg   <= FR_IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            par_reg        <= 1'b0;
            to_cnt_reg     <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            fr_state_reg   <= fr_state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            par_reg        <= par_next;
            byte_valid_reg <= byte_ok;
            frame_err_reg  <= frame_bad;
            if (fr_state_reg == FR_IDLE || fall_reg || timeout) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scancode decode (shift_reg holds the received byte until the next
    // frame starts shifting, so it is valid during byte_valid_reg)
    // ------------------------------------------------------------------
    logic       ext_reg;
    logic       brk_reg;
    logic [2:0] skip_reg;
    logic       is_prefix;
    logic       map_hit;
    logic [7:0] map_code;
    logic       push_req;

    ps2_uknc_map u_map (
        .ext      (ext_reg),
        .scancode (shift_reg),
        .hit      (map_hit),
        .keycode  (map_code)
    );

    assign is_prefix = (shift_reg == SC_E0) || (shift_reg == SC_F0) ||
                       (shift_reg == SC_E1);
    assign push_req  = byte_valid_reg && (skip_reg == 3'd0) && !is_prefix &&
                       !brk_reg && map_hit;

    always_ff @(posedge clk) begin
        if (nrst) begin
            ext_reg  <= 1'b0;
            brk_reg  <= 1'b0;
            skip_reg <= '0;
        end else if (byte_valid_reg) begin
            if (skip_reg != 3'd0) begin
                skip_reg <= skip_reg - 3'd1;
                ext_reg  <= 1'b0;
                brk_reg  <= 1'b0;
            end else begin
                case (shift_reg)
                    SC_E0: ext_reg <= 1'b1;
                    SC_F0: brk_reg <= 1'b1;
                    SC_E1: begin
                        skip_reg <= PAUSE_SKIP;
                        ext_reg  <= 1'b0;
                        brk_reg  <= 1'b0;
                    end
                    default: begin
                        ext_reg <= 1'b0;
                        brk_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Key FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          do_push;
    logic          overflow_reg;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign do_push    = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= map_code;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM
    // ------------------------------------------------------------------
    pres_state_t pr_state_reg, pr_state_next;
    logic        read_prev_reg;
    logic        read_rise;
    logic        load_key;
    logic [7:0]  keycode_reg;

    assign read_rise = kbd.read_kbd && !read_prev_reg;

    always_comb begin
        pr_state_next = pr_state_reg;
        pop           = 1'b0;
        load_key      = 1'b0;
        case (pr_state_reg)
            PR_EMPTY: begin
                if (!fifo_empty) begin
                    pr_state_next = PR_SHOW;
                    load_key      = 1'b1;
                end
            end
            PR_SHOW: begin
                if (read_rise) begin
                    pr_state_next = PR_GAP;
                    pop           = 1'b1;
                end
            end
            PR_GAP: begin
                // One cycle with press_btn low so every key gets a fresh edge
                if (!fifo_empty) begin
                    pr_state_next = PR_SHOW;
                    load_key      = 1'b1;
                end else begin
                    pr_state_next = PR_EMPTY;
                end
            end
            default: pr_state_next = PR_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            pr_state_reg  <= PR_EMPTY;
            read_prev_reg <= 1'b0;
            keycode_reg   <= '0;
        end else begin
            pr_state_reg  <= pr_state_next;
            read_prev_reg <= kbd.read_kbd;
            if (load_key) begin
                keycode_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign kbd.press_btn = (pr_state_reg == PR_SHOW);
    assign kbd.keycode   = {1'b0, keycode_reg[6:0]};
    assign frame_err     = frame_err_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_ps2_kbd_src.sv
// tb_ps2_kbd_src -- directed self-checking bench for ps2_kbd_src.
// Drives PS/2 frames bit by bit and checks the OSD key handshake.
module tb_ps2_kbd_src;

    localparam int HALF = 8;      // clk cycles per PS/2 clock half period
    localparam int TO   = 1000;   // shortened timeout for simulation

    logic clk;
    logic nrst;
    logic ps2_clk;
    logic ps2_data;
    logic frame_err;
    logic overflow;

    int total;
    int bad;
    int err_pulses;

    ps2_kbd_src_if kbd_if ();

    ps2_kbd_src #(
        .FIFO_DEPTH  (4),
        .FILTER_LEN  (4),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kbd       (kbd_if),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial err_pulses = 0;
    always @(posedge clk) begin
        if (!nrst && frame_err) err_pulses <= err_pulses + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(~bad_stop);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge on read_kbd; returns press_btn one cycle later
    task automatic ack(output logic seen_press);
        @(negedge clk);
        kbd_if.read_kbd = 1'b1;
        @(negedge clk);
        seen_press = kbd_if.press_btn;
        kbd_if.read_kbd = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(4);
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL reset_press got=%b exp=0", kbd_if.press_btn); end
        total++; if (kbd_if.keycode !== 8'h00) begin bad++; $display("FAIL reset_keycode got=%h exp=00", kbd_if.keycode); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        nrst = 1'b0;
        idle(10);
        $display("test_reset done");
    endtask

    task automatic test_latency();
        logic [7:0] d;
        logic seen;
        d = 8'h5A;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(1'b1);
        // stop bit driven by hand to time press_btn against the fall:
        // 2 sync + 4 filter edges give the fall strobe after edge 6,
        // press_btn follows 3 cycles later (after edge 9)
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", kbd_if.press_btn); end
        @(posedge clk);
        #1;
        total++; if (kbd_if.press_btn !== 1'b1) begin bad++; $display("FAIL lat_edge got=%b exp=1", kbd_if.press_btn); end
        total++; if (kbd_if.keycode !== 8'h6B) begin bad++; $display("FAIL lat_keycode got=%h exp=6b", kbd_if.keycode); end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        idle(40);
        total++; if (kbd_if.press_btn !== 1'b1 || kbd_if.keycode !== 8'h6B) begin
            bad++; $display("FAIL lat_hold got=%b/%h exp=1/6b", kbd_if.press_btn, kbd_if.keycode);
        end
        ack(seen);
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL lat_ack got=%b exp=0", seen); end
        idle(5);
        $display("test_latency done");
    endtask

    task automatic test_ext_break();
        logic seen;
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h75, 0, 0);   // plain 75 is unmapped: ext must be cleared
        total++; if (kbd_if.press_btn !== 1'b1 || kbd_if.keycode !== 8'h6C) begin
            bad++; $display("FAIL ext_up got=%b/%h exp=1/6c", kbd_if.press_btn, kbd_if.keycode);
        end
        ack(seen);
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ext_gap got=%b exp=0", seen); end
        idle(20);
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL ext_only_one got=%b exp=0", kbd_if.press_btn); end
        $display("test_ext_break done");
    endtask

    task automatic test_overflow();
        logic [7:0] exp_codes [4];
        logic seen;
        exp_codes = '{8'h6B, 8'h06, 8'h16, 8'h04};
        send_frame(8'h5A, 0, 0);
        send_frame(8'h76, 0, 0);
        send_frame(8'h0D, 0, 0);
        send_frame(8'h07, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int k = 0; k < 4; k++) begin
            total++; if (kbd_if.press_btn !== 1'b1 || kbd_if.keycode !== exp_codes[k]) begin
                bad++; $display("FAIL ovf_key%0d got=%b/%h exp=1/%h", k, kbd_if.press_btn, kbd_if.keycode, exp_codes[k]);
            end
            ack(seen);
            total++; if (seen !== 1'b0) begin bad++; $display("FAIL ovf_gap%0d got=%b exp=0", k, seen); end
            idle(5);
        end
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", kbd_if.press_btn); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        $display("test_overflow done");
    endtask

    task automatic test_frame_err();
        int e0;
        e0 = err_pulses;
        send_frame(8'h5A, 1, 0);
        send_frame(8'h5A, 0, 1);
        total++; if (err_pulses - e0 !== 2) begin bad++; $display("FAIL ferr_count got=%0d exp=2", err_pulses - e0); end
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL ferr_nokey got=%b exp=0", kbd_if.press_btn); end
        $display("test_frame_err done");
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_pulses;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        idle(TO + 50);
        total++; if (err_pulses - e0 !== 1) begin bad++; $display("FAIL tmo_err got=%0d exp=1", err_pulses - e0); end
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL tmo_nokey got=%b exp=0", kbd_if.press_btn); end
        send_frame(8'h76, 0, 0);
        total++; if (kbd_if.press_btn !== 1'b1 || kbd_if.keycode !== 8'h06) begin
            bad++; $display("FAIL tmo_esc got=%b/%h exp=1/06", kbd_if.press_btn, kbd_if.keycode);
        end
        total++; if (err_pulses - e0 !== 1) begin bad++; $display("FAIL tmo_clean got=%0d exp=1", err_pulses - e0); end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        nrst = 1'b1;
        kbd_if.read_kbd = 1'b1;
        idle(3);
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL rst_press got=%b exp=0", kbd_if.press_btn); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        total++; if (kbd_if.keycode !== 8'h00) begin bad++; $display("FAIL rst_keycode got=%h exp=00", kbd_if.keycode); end
        nrst = 1'b0;
        idle(30);
        total++; if (kbd_if.press_btn !== 1'b0) begin bad++; $display("FAIL rst_empty got=%b exp=0", kbd_if.press_btn); end
        send_frame(8'h07, 0, 0);
        total++; if (kbd_if.press_btn !== 1'b1 || kbd_if.keycode !== 8'h04) begin
            bad++; $display("FAIL rst_f12 got=%b/%h exp=1/04", kbd_if.press_btn, kbd_if.keycode);
        end
        idle(40);
        total++; if (kbd_if.press_btn !== 1'b1) begin bad++; $display("FAIL rst_held_read got=%b exp=1", kbd_if.press_btn); end
        kbd_if.read_kbd = 1'b0;
        $display("test_reset_mid done");
    endtask

    initial begin
        total = 0;
        bad = 0;
        nrst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        kbd_if.read_kbd = 1'b0;
        test_reset();
        test_latency();
        test_ext_break();
        test_overflow();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_kbd_src.md
Name: ps2_kbd_src

Overview:
- Keyboard-side source for the OSD menu key handshake (press_btn / keycode / read_kbd).
- Receives PS/2 frames from the host keyboard and decodes set-2 make codes, including E0/F0/E1 prefixes.
- Maps each decoded make code to a UKNC 7-bit keycode and queues it in a small FIFO.
- Presents one key at a time: press_btn rises for each key, and the OSD acknowledges it with read_kbd.

Parameters:
- FIFO_DEPTH, 4: key queue depth; must be a power of two, minimum 2.
- FILTER_LEN, 4: number of consecutive equal synchronized samples needed to accept a ps2_clk level change.
- TIMEOUT_CYC, 50000: number of clk cycles without a filtered ps2_clk falling edge that aborts a partial frame.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset; synchronous, active-high.
- ps2_clk  in  1  PS/2 clock line; asynchronous.
- ps2_data  in  1  PS/2 data line; asynchronous.
- press_btn  out  1  high while a key is presented; each presented key produces a fresh rising edge.
- keycode  out  8  UKNC keycode of the presented key; bit 7 is always 0.
- read_kbd  in  1  acknowledge; its rising edge pops the presented key.
- frame_err  out  1  one-cycle pulse on a parity error, a bad start or stop bit, or a timeout.
- overflow  out  1  sticky flag, set when a key is dropped because the FIFO is full.

Behaviour:
Reset:
- While nrst=1: press_btn=0, keycode=0, frame_err=0, overflow=0.
- FIFO empty; all FSMs idle; prefix flags and skip counter cleared.
- nrst asserted mid-frame discards the partial frame.

Input conditioning:
- ps2_clk and ps2_data pass through 2-flop synchronizers.
- ps2_clk is then glitch-filtered: the filtered level changes only after FILTER_LEN equal samples.
- A "fall" is a one-cycle strobe on each 1->0 transition of the filtered ps2_clk.
- ps2_data is sampled (synchronized value) in the fall cycle.

Frame FSM:
- IDLE -> DATA on a fall with data=0.
  - A fall with data=1 in IDLE stays in IDLE and pulses frame_err.
- DATA: shift 8 bits, LSB first, with a 3-bit counter -> PAR.
- PAR: capture the parity bit -> STOP.
- STOP: on the fall, check data=1 and odd parity over the 9 bits.
  - Pass: byte_valid strobe in the next cycle.
  - Fail: frame_err pulse, byte discarded.
  - Either way -> IDLE.
- Timeout: in any state other than IDLE, a 16-bit counter reaching TIMEOUT_CYC-1 without a fall -> IDLE plus frame_err pulse. The counter resets on every fall.

Decode, acting on byte_valid:
- E0 sets ext.
- F0 sets brk.
- E1 loads skip=7; the next 7 bytes are ignored and all flags cleared (Pause key).
- Any other byte:
  - If brk=0, look up {ext, byte}.
  - Then clear ext and brk.
  - Break codes never enqueue.

Key map (lookup result is valid or drop; unlisted codes drop):
- E0 75 -> o154 (up)
- E0 72 -> o134 (down)
- E0 6B -> o116 (left)
- E0 74 -> o133 (right)
- 5A -> o153 (enter)
- 76 -> o006 (ESC)
- 0D -> o026 (TAB)
- 07 -> o004 (F12, CPU reset)

FIFO:
- A mapped key is pushed 1 cycle after byte_valid.
- Full: the new key is dropped and overflow is set (sticky until reset).
- Push and pop in the same cycle are both honoured, including when the FIFO is full.

Presentation FSM:
- EMPTY -> SHOW when the FIFO is non-empty.
  - press_btn rises in the cycle after the FIFO becomes non-empty.
  - keycode = FIFO head, stable throughout SHOW.
- SHOW -> GAP on a read_kbd rising edge (read_kbd=1 now, 0 in the previous cycle). That cycle pops the FIFO; press_btn=0 in GAP.
- GAP lasts exactly 1 cycle -> SHOW if the FIFO is non-empty, else EMPTY.
- read_kbd held high does not pop again.
- A read_kbd edge seen outside SHOW is ignored.
- keycode holds its last value when press_btn=0.

Latency:
- Stop-bit fall at cycle T -> byte_valid at T+1 -> push at T+2 -> press_btn=1 at T+3, when the FIFO was empty.

Decomposition:
- Shared package ps2_kbd_pkg holds:
  - prefix constants E0, F0, E1;
  - UKNC keycode constants (KC_UP=o154, KC_DOWN=o134, KC_LEFT=o116, KC_RIGHT=o133, KC_ENTER=o153, KC_ESC=o006, KC_TAB=o026, KC_RESET=o004);
  - frame FSM and presentation FSM state enums.
- One sub-module, ps2_uknc_map: purely combinational. Inputs {ext, scancode[7:0]}; outputs {hit, keycode[7:0]}. Kept separate so the map can be extended independently.

Test Plan:
1. Frame 5A (parity 1, stop 1), no read_kbd -> press_btn=1 exactly 3 cycles after the stop fall; keycode=0x6B (o153); stays presented.
2. Frames E0 75, then E0 F0 75 -> exactly one key o154 queued; the break enqueues nothing.
3. Five mapped keys sent with no acknowledge (FIFO_DEPTH=4) -> overflow=1. Then pulse read_kbd 4 times -> the first 4 codes appear in order, press_btn low for ≥1 cycle between keys.
4. Frame with bad parity, then a frame with stop=0 -> two frame_err pulses; no key queued.
5. 4 bits of a frame, then idle for TIMEOUT_CYC cycles -> frame_err pulse. A following valid 76 frame -> keycode=o006.
6. Assert nrst while a key is presented and read_kbd is held high -> press_btn=0, overflow=0, FIFO empty. Afterwards a new 07 frame -> press_btn rises with keycode=o004, and the still-high read_kbd does not pop it.
